// File: rtl/axi_ram_rw.sv
// axi_ram_rw: AXI4 slave RAM with independent read and write burst engines over one word array.
// FIXED/INCR/WRAP bursts, byte strobes, SLVERR on decode faults; reads see pre-write data on collisions.
module axi_ram_rw #(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              axi_slv_awvalid_i,
  output logic              axi_slv_awready_o,
  input  logic [ID_W-1:0]   axi_slv_awid_i,
  input  logic [ADDR_W-1:0] axi_slv_awaddr_i,
  input  logic [7:0]        axi_slv_awlen_i,
  input  logic [2:0]        axi_slv_awsize_i,
  input  logic [1:0]        axi_slv_awburst_i,
  input  logic              axi_slv_awlock_i,
  input  logic [3:0]        axi_slv_awcache_i,
  input  logic [2:0]        axi_slv_awprot_i,
  input  logic [3:0]        axi_slv_awqos_i,
  input  logic [3:0]        axi_slv_awregion_i,
  input  logic              axi_slv_wvalid_i,
  output logic              axi_slv_wready_o,
  input  logic [DATA_W-1:0] axi_slv_wdata_i,
  input  logic [DATA_W/8-1:0] axi_slv_wstrb_i,
  input  logic              axi_slv_wlast_i,
  output logic              axi_slv_bvalid_o,
  input  logic              axi_slv_bready_i,
  output logic [ID_W-1:0]   axi_slv_bid_o,
  output logic [1:0]        axi_slv_bresp_o,
  input  logic              axi_slv_arvalid_i,
  output logic              axi_slv_arready_o,
  input  logic [ID_W-1:0]   axi_slv_arid_i,
  input  logic [ADDR_W-1:0] axi_slv_araddr_i,
  input  logic [7:0]        axi_slv_arlen_i,
  input  logic [2:0]        axi_slv_arsize_i,
  input  logic [1:0]        axi_slv_arburst_i,
  input  logic              axi_slv_arlock_i,
  input  logic [3:0]        axi_slv_arcache_i,
  input  logic [2:0]        axi_slv_arprot_i,
  input  logic [3:0]        axi_slv_arqos_i,
  input  logic [3:0]        axi_slv_arregion_i,
  output logic              axi_slv_rvalid_o,
  input  logic              axi_slv_rready_i,
  output logic [ID_W-1:0]   axi_slv_rid_o,
  output logic [DATA_W-1:0] axi_slv_rdata_o,
  output logic [1:0]        axi_slv_rresp_o,
  output logic              axi_slv_rlast_o
);
  localparam int LSB    = $clog2(DATA_W/8);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int STRB_W = DATA_W/8;

  typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_e;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [2:0] size,
                                                  input logic [7:0] len, input logic [1:0] burst);
    logic [ADDR_W-1:0] step, mask;
    step = ADDR_W'(1) << size;
    mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    return burst == 2'b00 ? a : burst == 2'b10 ? (a & ~mask) | ((a + step) & mask) : a + step;
  endfunction

  function automatic logic oob(input logic [ADDR_W-1:0] a);
    return (a >> LSB) >= ADDR_W'(MEM_DEPTH);
  endfunction

  function automatic logic bad(input logic [ADDR_W-1:0] a, input logic [2:0] size,
                               input logic [7:0] len, input logic [1:0] burst);
    return oob(a) || size > 3'(LSB) || burst == 2'b11 ||
           (burst == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic unused_ok;
  assign unused_ok = ^{axi_slv_awlock_i, axi_slv_awcache_i, axi_slv_awprot_i, axi_slv_awqos_i, axi_slv_awregion_i,
                       axi_slv_arlock_i, axi_slv_arcache_i, axi_slv_arprot_i, axi_slv_arqos_i, axi_slv_arregion_i};

  rd_state_e rd_state_q, rd_state_d;
  logic [ID_W-1:0] rd_id_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [7:0] rd_len_q, rd_cnt_q;
  logic [2:0] rd_size_q;
  logic [1:0] rd_burst_q;
  logic rd_oob_q, rd_err_q, ar_hs, r_hs;

  assign axi_slv_arready_o = rd_state_q == RD_IDLE;
  assign axi_slv_rvalid_o  = rd_state_q == RD_DATA;
  assign axi_slv_rid_o     = rd_id_q;
  assign axi_slv_rdata_o   = rd_oob_q ? '0 : mem_q[rd_addr_q[LSB+:IDX_W]];
  assign axi_slv_rresp_o   = {axi_slv_rvalid_o && rd_err_q, 1'b0};
  assign axi_slv_rlast_o   = axi_slv_rvalid_o && rd_cnt_q == rd_len_q;
  assign ar_hs = axi_slv_arvalid_i && axi_slv_arready_o;
  assign r_hs  = axi_slv_rvalid_o && axi_slv_rready_i;

  always_comb rd_state_d = ar_hs ? RD_DATA : (r_hs && axi_slv_rlast_o) ? RD_IDLE : rd_state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state_q <= RD_IDLE;
      rd_id_q    <= '0;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      rd_cnt_q   <= '0;
      rd_size_q  <= '0;
      rd_burst_q <= '0;
      rd_oob_q   <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      if (ar_hs) begin
        rd_id_q    <= axi_slv_arid_i;
        rd_addr_q  <= axi_slv_araddr_i;
        rd_len_q   <= axi_slv_arlen_i;
        rd_cnt_q   <= '0;
        rd_size_q  <= axi_slv_arsize_i;
        rd_burst_q <= axi_slv_arburst_i;
        rd_oob_q   <= oob(axi_slv_araddr_i);
        rd_err_q   <= bad(axi_slv_araddr_i, axi_slv_arsize_i, axi_slv_arlen_i, axi_slv_arburst_i);
      end else if (r_hs) begin
        rd_addr_q <= next_addr(rd_addr_q, rd_size_q, rd_len_q, rd_burst_q);
        rd_cnt_q  <= rd_cnt_q + 8'd1;
      end
    end
  end

  wr_state_e wr_state_q, wr_state_d;
  logic [ID_W-1:0] wr_id_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0] wr_len_q, wr_cnt_q;
  logic [2:0] wr_size_q;
  logic [1:0] wr_burst_q;
  logic wr_oob_q, wr_err_q, aw_hs, w_hs, b_hs;

  assign axi_slv_awready_o = wr_state_q == WR_IDLE;
  assign axi_slv_wready_o  = wr_state_q == WR_DATA;
  assign axi_slv_bvalid_o  = wr_state_q == WR_RESP;
  assign axi_slv_bid_o     = wr_id_q;
  assign axi_slv_bresp_o   = {axi_slv_bvalid_o && wr_err_q, 1'b0};
  assign aw_hs = axi_slv_awvalid_i && axi_slv_awready_o;
  assign w_hs  = axi_slv_wvalid_i && axi_slv_wready_o;
  assign b_hs  = axi_slv_bvalid_o && axi_slv_bready_i;

  always_comb wr_state_d = aw_hs ? WR_DATA : (w_hs && axi_slv_wlast_i) ? WR_RESP : b_hs ? WR_IDLE : wr_state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state_q <= WR_IDLE;
      wr_id_q    <= '0;
      wr_addr_q  <= '0;
      wr_len_q   <= '0;
      wr_cnt_q   <= '0;
      wr_size_q  <= '0;
      wr_burst_q <= '0;
      wr_oob_q   <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      if (aw_hs) begin
        wr_id_q    <= axi_slv_awid_i;
        wr_addr_q  <= axi_slv_awaddr_i;
        wr_len_q   <= axi_slv_awlen_i;
        wr_cnt_q   <= '0;
        wr_size_q  <= axi_slv_awsize_i;
        wr_burst_q <= axi_slv_awburst_i;
        wr_oob_q   <= oob(axi_slv_awaddr_i);
        wr_err_q   <= bad(axi_slv_awaddr_i, axi_slv_awsize_i, axi_slv_awlen_i, axi_slv_awburst_i);
      end else if (w_hs) begin
        wr_addr_q <= next_addr(wr_addr_q, wr_size_q, wr_len_q, wr_burst_q);
        wr_cnt_q  <= wr_cnt_q + 8'd1;
        if (axi_slv_wlast_i && wr_cnt_q != wr_len_q) wr_err_q <= 1'b1;
      end
    end
  end

  // Out-of-range bursts still consume W beats but never touch the array
  always_ff @(posedge clk) begin
    if (w_hs && !wr_oob_q)
      for (int i = 0; i < STRB_W; i++)
        if (axi_slv_wstrb_i[i]) mem_q[wr_addr_q[LSB+:IDX_W]][8*i+:8] <= axi_slv_wdata_i[8*i+:8];
  end
endmodule

// File: doc/axi_ram_rw.md
# axi_ram_rw

Parametrised AXI4 slave memory with full read (AR/R) and write (AW/W/B) channels, FIXED/INCR/WRAP bursts, narrow transfers and byte strobes. Successor to the read-only AXI memory: same slot on the interconnect as a boot/scratch RAM, now writable and sized per instance. Read and write engines are independent FSMs sharing one word array.

## Interface
- ID_W, 4: AXI ID width.
- ADDR_W, 32: AXI address width.
- DATA_W, 32: data width; 32 or 64.
- MEM_DEPTH, 2048: words in the array; power of two.
- Derived: LSB = log2(DATA_W/8); IDX_W = log2(MEM_DEPTH).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- axi_slv_awvalid/awready  in/out  1  AW handshake; awid ID_W, awaddr ADDR_W, awlen 8, awsize 3, awburst 2 (inputs).
- axi_slv_wvalid/wready  in/out  1  W handshake; wdata DATA_W, wstrb DATA_W/8, wlast 1 (inputs).
- axi_slv_bvalid/bready  out/in  1  B handshake; bid ID_W, bresp 2 (outputs).
- axi_slv_arvalid/arready  in/out  1  AR handshake; arid ID_W, araddr ADDR_W, arlen 8, arsize 3, arburst 2 (inputs).
- axi_slv_rvalid/rready  out/in  1  R handshake; rid ID_W, rdata DATA_W, rresp 2, rlast 1 (outputs).
- Lock/cache/prot/qos/region inputs are accepted and ignored.

## Operation
- Read FSM RD_IDLE -> RD_DATA -> RD_IDLE. arready = 1 only in RD_IDLE. On AR handshake latch id, addr, len, size, burst; beat count = 0.
- RD_DATA: rvalid = 1; rdata = array[addr[LSB+:IDX_W]] (combinational from latched beat address); rlast = (count == len). On R handshake: advance address, count+1; on last beat return to RD_IDLE.
- Write FSM WR_IDLE -> WR_DATA -> WR_RESP -> WR_IDLE. awready = 1 only in WR_IDLE; wready = 1 only in WR_DATA; bvalid = 1 only in WR_RESP.
- On W handshake write each byte lane i with wstrb[i] = 1; advance address; count+1. Burst ends on the beat with wlast = 1 -> WR_RESP. B handshake -> WR_IDLE.
- Address advance: FIXED holds; INCR adds 1<<size; WRAP adds 1<<size, wrapping within aligned block of (len+1)<<size bytes. Reserved burst 2'b11 advances as INCR.
- Errors -> resp SLVERR (2'b10), else OKAY (2'b00):
  - word index of start address >= MEM_DEPTH: reads return rdata 0 on every beat; writes are suppressed, W beats still consumed.
  - size > LSB, or burst = 2'b11.
  - WRAP with len not in {1,3,7,15}.
  - write: wlast on a beat where count != len (bresp only; data written).
- Write whose wlast never arrives by beat len continues accepting beats until wlast.
- Same-word read and write in the same cycle: rdata returns the pre-write value; new value is visible next cycle.
- No reordering or interleaving: one read burst and one write burst outstanding max.

## Timing
- Reset (rst_n = 0 at a rising edge): both FSMs to IDLE. arready = 1, awready = 1, wready = 0, rvalid = 0, bvalid = 0, rlast = 0, rresp = 0, bresp = 0, rid = 0, bid = 0. Array contents are not reset. Reset mid-burst aborts it with no response.
- AR handshake in cycle N -> rvalid = 1 in N+1. With rready held high, one beat per cycle; burst of L+1 beats ends in N+L+1. arready returns in the cycle after the last-beat handshake.
- AW handshake in cycle N -> wready = 1 in N+1. With wvalid held high, one beat per cycle. wlast handshake in M -> bvalid = 1 in M+1.
- rvalid, rdata, rid, rresp, rlast and bvalid, bid, bresp hold stable while the corresponding ready is low.
- Read and write channels run concurrently with no mutual stall.

## Test plan
- Reset then single write 0x100 = 0xDEADBEEF, strb 4'hF -> bresp 0 one cycle after wlast; read 0x100 len 0 -> rdata 0xDEADBEEF, rlast 1, rresp 0, rvalid in cycle after AR handshake.
- INCR write len 3 from 0x200 (data 1..4), then INCR read len 3 with rready toggling every other cycle -> data 1,2,3,4 in order, stable while stalled, rlast on 4th.
- WRAP read len 3 size 2 from 0x0C after filling 0x00..0x0C with A,B,C,D -> beats D,A,B,C; arid 5 echoed as rid 5.
- Byte strobes: write 0x11223344 to 0x40 strb 4'b0101 over prior 0xFFFFFFFF -> read returns 0xFF22FF44.
- Out-of-range: write/read at word index MEM_DEPTH -> bresp 2'b10, no array change; rdata 0, rresp 2'b10. Early wlast on beat 1 of len 3 -> bresp 2'b10.
- Concurrent read and write same word same cycle -> old data returned; rst_n low mid-read -> rvalid 0 next cycle, arready 1.
